// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared widths, write-entry layout and small helpers for the register file
// write-side arbiter. The xgriscv defines are guarded so a project-wide
// header that already defines them takes precedence.
`ifndef XGRISCV_DEFINES
`define XGRISCV_DEFINES
`define XLEN           32
`define RFIDX_WIDTH    5
`define RFREG_NUM      32
`define WB_ENTRY_WIDTH (`RFIDX_WIDTH+`XLEN)
`endif

package rf_writeback_arbiter_pkg;

    localparam int XLEN           = `XLEN;
    localparam int RFIDX_WIDTH    = `RFIDX_WIDTH;
    localparam int RFREG_NUM      = `RFREG_NUM;
    localparam int WB_ENTRY_WIDTH = `WB_ENTRY_WIDTH;

    // One pending register-file write: destination index plus result.
    typedef struct packed {
        logic [RFIDX_WIDTH-1:0] rd;
        logic [XLEN-1:0]        data;
    } wb_entry_t;

    // Which source owns the write port in a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_e;

    // x0 is hard-wired to zero, so a write to it is swallowed.
    function automatic logic isRealWrite(input logic [RFIDX_WIDTH-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/rf_writeback_arbiter_wb_fifo.sv
// Small first-in first-out buffer holding multi-cycle unit results until
// they win the register file write port. Pointers wrap modulo DEPTH.
module wb_fifo
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      i_push,
    input  wb_entry_t i_pushEntry,
    input  logic      i_pop,
    output logic      o_full,
    output logic      o_empty,
    output wb_entry_t o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WB_ENTRY_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]          r_wrPtr;
    logic [PTR_W-1:0]          r_rdPtr;
    logic [CNT_W-1:0]          r_count;
    logic                      w_doPush;
    logic                      w_doPop;

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_head   = wb_entry_t'(r_mem[r_rdPtr]);
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    // Advance pointers and track occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            if (w_doPush && !w_doPop)      r_count <= r_count + CNT_W'(1);
            else if (w_doPop && !w_doPush) r_count <= r_count - CNT_W'(1);
        end
    end

    // Entry storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= WB_ENTRY_WIDTH'(i_pushEntry);
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register file write-side front end: merges in-order pipeline writebacks
// with buffered multi-cycle results (one write per cycle), prevents the
// buffer from starving, and tracks registers awaiting a multi-cycle write.
module rf_writeback_arbiter
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   pipe_valid,
    input  logic [RFIDX_WIDTH-1:0] pipe_rd,
    input  logic [XLEN-1:0]        pipe_data,
    output logic                   pipe_stall,
    input  logic                   mc_valid,
    output logic                   mc_ready,
    input  logic [RFIDX_WIDTH-1:0] mc_rd,
    input  logic [XLEN-1:0]        mc_data,
    input  logic                   iss_valid,
    input  logic [RFIDX_WIDTH-1:0] iss_rd,
    input  logic [RFIDX_WIDTH-1:0] chk_ra1,
    input  logic [RFIDX_WIDTH-1:0] chk_ra2,
    output logic                   busy1,
    output logic                   busy2,
    output logic                   we3,
    output logic [RFIDX_WIDTH-1:0] wa3,
    output logic [XLEN-1:0]        wd3
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    wb_entry_t              w_mcEntry;
    wb_entry_t              w_head;
    wb_entry_t              w_winner;
    wb_src_e                w_src;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_wbFire;
    logic [STARVE_W-1:0]    r_starveCnt;
    logic [RFREG_NUM-1:0]   r_pending;
    logic [RFREG_NUM-1:0]   w_pendingNext;
    logic                   r_we3;
    logic [RFIDX_WIDTH-1:0] r_wa3;
    logic [XLEN-1:0]        r_wd3;

    assign w_mcEntry  = '{rd: mc_rd, data: mc_data};
    assign mc_ready   = rstn && !w_full;
    assign w_push     = mc_valid && mc_ready;
    assign pipe_stall = (r_starveCnt == STARVE_W'(STARVE_MAX)) && !w_empty;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .i_push     (w_push),
        .i_pushEntry(w_mcEntry),
        .i_pop      (w_pop),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head     (w_head)
    );

    // Pick this cycle's write: pipeline first unless it is being held off for the buffer.
    always_comb begin
        w_src    = SRC_NONE;
        w_winner = w_head;
        if (pipe_valid && !pipe_stall) begin
            w_src    = SRC_PIPE;
            w_winner = '{rd: pipe_rd, data: pipe_data};
        end else if (!w_empty) begin
            w_src = SRC_FIFO;
        end
    end

    assign w_pop    = (w_src == SRC_FIFO);
    assign w_wbFire = (w_src != SRC_NONE) && isRealWrite(w_winner.rd);

    // Register the write port; address and data hold when nothing real is written.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_we3 <= 1'b0;
            r_wa3 <= '0;
            r_wd3 <= '0;
        end else begin
            r_we3 <= w_wbFire;
            if (w_wbFire) begin
                r_wa3 <= w_winner.rd;
                r_wd3 <= w_winner.data;
            end
        end
    end

    assign we3 = r_we3;
    assign wa3 = r_wa3;
    assign wd3 = r_wd3;

    // Count cycles a waiting buffer loses to the pipeline, saturating at the limit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_starveCnt <= '0;
        end else if (w_empty || w_pop) begin
            r_starveCnt <= '0;
        end else if (r_starveCnt != STARVE_W'(STARVE_MAX)) begin
            r_starveCnt <= r_starveCnt + STARVE_W'(1);
        end
    end

    // Next pending set: a popped entry clears its register, a new issue sets it and wins.
    always_comb begin
        w_pendingNext = r_pending;
        if (w_pop && isRealWrite(w_head.rd)) w_pendingNext[w_head.rd] = 1'b0;
        if (iss_valid && isRealWrite(iss_rd)) w_pendingNext[iss_rd] = 1'b1;
    end

    // Hold the pending-write scoreboard.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_pending <= '0;
        else       r_pending <= w_pendingNext;
    end

    assign busy1 = r_pending[chk_ra1] && isRealWrite(chk_ra1);
    assign busy2 = r_pending[chk_ra2] && isRealWrite(chk_ra2);

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Self-checking bench for rf_writeback_arbiter: table-driven pipeline
// writes plus hand-written multi-cycle sequences, with every register file
// write checked in order against a queue of expected writes.
module tb_rf_writeback_arbiter;
    import rf_writeback_arbiter_pkg::*;

    logic                   clk;
    logic                   rstn;
    logic                   pipe_valid;
    logic [RFIDX_WIDTH-1:0] pipe_rd;
    logic [XLEN-1:0]        pipe_data;
    logic                   pipe_stall;
    logic                   mc_valid;
    logic                   mc_ready;
    logic [RFIDX_WIDTH-1:0] mc_rd;
    logic [XLEN-1:0]        mc_data;
    logic                   iss_valid;
    logic [RFIDX_WIDTH-1:0] iss_rd;
    logic [RFIDX_WIDTH-1:0] chk_ra1;
    logic [RFIDX_WIDTH-1:0] chk_ra2;
    logic                   busy1;
    logic                   busy2;
    logic                   we3;
    logic [RFIDX_WIDTH-1:0] wa3;
    logic [XLEN-1:0]        wd3;

    int        nChecks = 0;
    int        nPass   = 0;
    wb_entry_t expQ [$];
    logic [XLEN-1:0] rfModel [RFREG_NUM];

    typedef struct {
        logic                   pv;
        logic [RFIDX_WIDTH-1:0] rd;
        logic [XLEN-1:0]        data;
        logic                   expWe;
        logic                   chkAddr;
        logic [RFIDX_WIDTH-1:0] expWa;
        logic [XLEN-1:0]        expWd;
    } vec_t;

    localparam int NUM_VECS = 7;
    vec_t vecs [NUM_VECS];

    rf_writeback_arbiter #(
        .DEPTH     (4),
        .STARVE_MAX(3)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .pipe_valid(pipe_valid),
        .pipe_rd   (pipe_rd),
        .pipe_data (pipe_data),
        .pipe_stall(pipe_stall),
        .mc_valid  (mc_valid),
        .mc_ready  (mc_ready),
        .mc_rd     (mc_rd),
        .mc_data   (mc_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .chk_ra1   (chk_ra1),
        .chk_ra2   (chk_ra2),
        .busy1     (busy1),
        .busy2     (busy2),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic pv, input logic [RFIDX_WIDTH-1:0] prd, input logic [XLEN-1:0] pd,
                                 input logic mv, input logic [RFIDX_WIDTH-1:0] mrd, input logic [XLEN-1:0] md,
                                 input logic iv, input logic [RFIDX_WIDTH-1:0] ird);
        pipe_valid = pv;
        pipe_rd    = prd;
        pipe_data  = pd;
        mc_valid   = mv;
        mc_rd      = mrd;
        mc_data    = md;
        iss_valid  = iv;
        iss_rd     = ird;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic expectWrite(input logic [RFIDX_WIDTH-1:0] rd, input logic [XLEN-1:0] data);
        wb_entry_t e;
        if (rd != '0) begin
            e.rd   = rd;
            e.data = data;
            expQ.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Register file model latching on the falling edge inside the write cycle.
    always @(negedge clk) begin
        if (rstn === 1'b1 && we3 === 1'b1) rfModel[wa3] <= wd3;
    end

    // Every write the DUT issues must match the oldest expected write.
    always @(negedge clk) begin
        wb_entry_t e;
        if (rstn === 1'b1 && we3 === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected write addr", 64'(wa3), 64'hFFFF_FFFF);
            end else begin
                e = expQ.pop_front();
                checkOutput("write addr", 64'(wa3), 64'(e.rd));
                checkOutput("write data", 64'(wd3), 64'(e.data));
            end
        end
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        logic expStall;
        logic expReady;
        int   pipeIdx;
        int   popIdx;

        vecs[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b1, 1'b1, 5'd3,  32'hDEADBEEF};
        vecs[1] = '{1'b1, 5'd0,  32'h11111111, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[2] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF};
        vecs[3] = '{1'b0, 5'd4,  32'h00005555, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFF};
        vecs[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 1'b1, 5'd1,  32'h00000000};
        vecs[5] = '{1'b1, 5'd17, 32'hCAFEF00D, 1'b1, 1'b1, 5'd17, 32'hCAFEF00D};
        vecs[6] = '{1'b0, 5'd0,  32'h00000000, 1'b0, 1'b1, 5'd17, 32'hCAFEF00D};

        rstn    = 1'b0;
        chk_ra1 = '0;
        chk_ra2 = '0;
        idle();
        step();
        step();
        checkOutput("reset we3", 64'(we3), 64'(0));
        checkOutput("reset wa3", 64'(wa3), 64'(0));
        checkOutput("reset wd3", 64'(wd3), 64'(0));
        checkOutput("reset mc_ready", 64'(mc_ready), 64'(0));
        checkOutput("reset pipe_stall", 64'(pipe_stall), 64'(0));
        rstn = 1'b1;
        #1;
        checkOutput("post-reset mc_ready", 64'(mc_ready), 64'(1));

        // Pipeline writes from the vector table.
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].pv, vecs[i].rd, vecs[i].data, 1'b0, '0, '0, 1'b0, '0);
            if (vecs[i].pv) expectWrite(vecs[i].rd, vecs[i].data);
            step();
            checkOutput($sformatf("vec%0d we3", i), 64'(we3), 64'(vecs[i].expWe));
            if (vecs[i].chkAddr) begin
                checkOutput($sformatf("vec%0d wa3", i), 64'(wa3), 64'(vecs[i].expWa));
                checkOutput($sformatf("vec%0d wd3", i), 64'(wd3), 64'(vecs[i].expWd));
            end
        end
        idle();
        @(negedge clk);
        #1;
        checkOutput("rf readback x3", 64'(rfModel[3]), 64'(32'hDEADBEEF));
        checkOutput("rf readback x31", 64'(rfModel[31]), 64'(32'hFFFFFFFF));
        checkOutput("rf readback x17", 64'(rfModel[17]), 64'(32'hCAFEF00D));
        step();

        // Multi-cycle flow: issue x7, result four cycles later, written two cycles after acceptance.
        chk_ra1 = 5'd7;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        step();
        idle();
        for (int k = 1; k <= 3; k++) begin
            checkOutput($sformatf("mc busy1 issue+%0d", k), 64'(busy1), 64'(1));
            step();
        end
        checkOutput("mc busy1 issue+4", 64'(busy1), 64'(1));
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 32'h00000012, 1'b0, '0);
        expectWrite(5'd7, 32'h00000012);
        step();
        idle();
        checkOutput("mc we3 accept+1", 64'(we3), 64'(0));
        checkOutput("mc busy1 accept+1", 64'(busy1), 64'(1));
        step();
        checkOutput("mc we3 accept+2", 64'(we3), 64'(1));
        checkOutput("mc busy1 cleared", 64'(busy1), 64'(0));
        step();

        // x0 writes from both sources are consumed silently.
        applyStimulus(1'b1, 5'd0, 32'h00001234, 1'b1, 5'd0, 32'h00005678, 1'b0, '0);
        step();
        idle();
        checkOutput("x0 pipe we3", 64'(we3), 64'(0));
        step();
        checkOutput("x0 fifo we3", 64'(we3), 64'(0));
        checkOutput("x0 mc_ready", 64'(mc_ready), 64'(1));
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd12, 32'h00000C0C, 1'b0, '0);
        expectWrite(5'd12, 32'h00000C0C);
        step();
        idle();
        checkOutput("after x0 we3 early", 64'(we3), 64'(0));
        step();
        checkOutput("after x0 we3 on time", 64'(we3), 64'(1));
        step();

        // Back-pressure: four results pushed behind a continuously busy pipeline.
        pipeIdx = 0;
        popIdx  = 0;
        for (int c = 0; c < 18; c++) begin
            expStall = (c == 4) || (c == 8) || (c == 12) || (c == 16);
            expReady = (c != 4);
            checkOutput($sformatf("bp c%0d pipe_stall", c), 64'(pipe_stall), 64'(expStall));
            checkOutput($sformatf("bp c%0d mc_ready", c), 64'(mc_ready), 64'(expReady));
            applyStimulus(1'b1, 5'(10 + pipeIdx), 32'hA0000000 + 32'(pipeIdx),
                          (c < 4), 5'(24 + c), 32'hB0000000 + 32'(c), 1'b0, '0);
            if (expStall) begin
                expectWrite(5'(24 + popIdx), 32'hB0000000 + 32'(popIdx));
                popIdx++;
            end else begin
                expectWrite(5'(10 + pipeIdx), 32'hA0000000 + 32'(pipeIdx));
                pipeIdx++;
            end
            step();
        end
        idle();
        step();
        step();

        // Issue and pop of the same register in one cycle leaves it pending.
        chk_ra2 = 5'd9;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
        step();
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'h00000099, 1'b0, '0);
        expectWrite(5'd9, 32'h00000099);
        checkOutput("coll busy2 after issue", 64'(busy2), 64'(1));
        step();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
        step();
        checkOutput("coll we3", 64'(we3), 64'(1));
        checkOutput("coll busy2 set wins", 64'(busy2), 64'(1));
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'h0000009A, 1'b0, '0);
        expectWrite(5'd9, 32'h0000009A);
        step();
        idle();
        step();
        checkOutput("coll final we3", 64'(we3), 64'(1));
        checkOutput("coll busy2 cleared", 64'(busy2), 64'(0));
        step();

        // Reset mid-stream with two buffered results and x5 pending.
        chk_ra1 = 5'd5;
        applyStimulus(1'b1, 5'd20, 32'hC0DE0000, 1'b1, 5'd21, 32'hD0000001, 1'b1, 5'd5);
        expectWrite(5'd20, 32'hC0DE0000);
        step();
        applyStimulus(1'b1, 5'd22, 32'hC0DE0001, 1'b1, 5'd23, 32'hD0000002, 1'b0, '0);
        expectWrite(5'd22, 32'hC0DE0001);
        step();
        idle();
        checkOutput("pre-reset busy1 x5", 64'(busy1), 64'(1));
        checkOutput("pre-reset pipe_stall", 64'(pipe_stall), 64'(0));
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("mid reset we3", 64'(we3), 64'(0));
        checkOutput("mid reset wa3", 64'(wa3), 64'(0));
        checkOutput("mid reset wd3", 64'(wd3), 64'(0));
        checkOutput("mid reset mc_ready", 64'(mc_ready), 64'(0));
        checkOutput("mid reset busy1 x5", 64'(busy1), 64'(0));
        checkOutput("mid reset pipe_stall", 64'(pipe_stall), 64'(0));
        step();
        step();
        rstn = 1'b1;
        #1;
        checkOutput("release mc_ready", 64'(mc_ready), 64'(1));
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput($sformatf("release idle%0d we3", k), 64'(we3), 64'(0));
            checkOutput($sformatf("release idle%0d busy1", k), 64'(busy1), 64'(0));
        end

        @(negedge clk);
        #1;
        checkOutput("expected writes drained", 64'(expQ.size()), 64'(0));
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
